mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_rr_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared encodings for the memory port arbiter: FSM state
//               codes (IDLE/REQ/RSP) and the owner code identifying which
//               requester (instruction fetch or data) holds the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_RSP   = 2'd2;

    // Owner encoding
    localparam logic       c_OWN_I = 1'b0;
    localparam logic       c_OWN_D = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_pick
// Description : Two-way winner selection between the instruction and data
//               requesters. A lone requester always wins. On a tie the
//               winner is the requester that did not own the port last,
//               unless fixed priority is selected, in which case data wins.
// Ports       : i_inst_valid  - instruction requester valid
//               i_data_valid  - data requester valid
//               i_last_owner  - owner of the last completed transaction
//               i_fix_prio    - 1: data always wins ties
//               o_winner      - selected owner (c_OWN_I / c_OWN_D)
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic i_inst_valid,
    input  logic i_data_valid,
    input  logic i_last_owner,
    input  logic i_fix_prio,
    output logic o_winner
);

    always_comb begin
        o_winner = c_OWN_I;
        if (i_inst_valid && i_data_valid) begin
            // Tie: fixed priority favours data, otherwise take the other one
            o_winner = i_fix_prio ? c_OWN_D : ~i_last_owner;
        end else if (i_data_valid) begin
            o_winner = c_OWN_D;
        end
    end

endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between an instruction-fetch
//               requester (i_*) and a data requester (d_*). At most one
//               memory transaction is outstanding. FSM: IDLE picks a winner,
//               REQ presents the owner's request on m_*, RSP routes the read
//               response back to the owner only.
// Parameters  : FIX_PRIO - 0: round-robin ties, 1: data wins ties
// Macros      : MEM_ARB_PERF_EN - enables the conflict_cnt counter;
//               without it conflict_cnt is tied to zero.
// Ports       : clk, rst (synchronous, active-high)
//               i_req_valid/i_addr/i_req_ready    fetch request
//               i_rdata/i_rvalid/i_rready          fetch response
//               d_read/d_write/d_addr/d_wdata/d_wstrb/d_req_ready  data req
//               d_rdata/d_rvalid/d_rready          data response
//               m_addr/m_wdata/m_wstrb/m_read/m_write/m_req_ready  mem req
//               m_rdata/m_rvalid/m_rready          memory response
//               conflict_cnt                       arbitration-loss cycles
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FIX_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    // Instruction fetch requester
    input  logic        i_req_valid,
    input  logic [31:0] i_addr,
    output logic        i_req_ready,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    input  logic        i_rready,
    // Data requester
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_req_ready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    input  logic        d_rready,
    // Unified memory port
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_read,
    output logic        m_write,
    input  logic        m_req_ready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready,
    // Performance
    output logic [31:0] conflict_cnt
);

    localparam logic c_FIX_PRIO = (FIX_PRIO != 0);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       r_last_owner;
    logic       w_last_owner_nxt;

    logic       w_d_valid;
    logic       w_own_d;
    logic       w_owner_valid;
    logic       w_owner_write;
    logic       w_owner_rready;
    logic       w_winner;

    // A simultaneous read+write is a write
    assign w_d_valid      = d_read | d_write;
    assign w_own_d        = (r_owner == c_OWN_D);
    assign w_owner_valid  = w_own_d ? w_d_valid : i_req_valid;
    assign w_owner_write  = w_own_d & d_write;
    assign w_owner_rready = w_own_d ? d_rready : i_rready;

    arb_rr_pick u_pick (
        .i_inst_valid (i_req_valid),
        .i_data_valid (w_d_valid),
        .i_last_owner (r_last_owner),
        .i_fix_prio   (c_FIX_PRIO),
        .o_winner     (w_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner      <= c_OWN_I;
            r_last_owner <= c_OWN_D;   // instruction wins the first tie
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        i_req_ready      = 1'b0;
        i_rdata          = '0;
        i_rvalid         = 1'b0;
        d_req_ready      = 1'b0;
        d_rdata          = '0;
        d_rvalid         = 1'b0;
        m_addr           = '0;
        m_wdata          = '0;
        m_wstrb          = '0;
        m_read           = 1'b0;
        m_write          = 1'b0;
        m_rready         = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (i_req_valid || w_d_valid) begin
                    w_owner_nxt = w_winner;
                    w_state_nxt = c_REQ;
                end
            end

            c_REQ: begin
                if (!w_owner_valid) begin
                    // Request withdrawn before acceptance: nothing issued
                    w_state_nxt = c_IDLE;
                end else begin
                    if (w_own_d) begin
                        m_addr      = d_addr;
                        m_wdata     = d_wdata;
                        m_wstrb     = d_wstrb;
                        m_write     = d_write;
                        m_read      = d_read & ~d_write;
                        d_req_ready = m_req_ready;
                    end else begin
                        m_addr      = i_addr;
                        m_read      = 1'b1;
                        i_req_ready = m_req_ready;
                    end
                    if (m_req_ready) begin
                        if (w_owner_write) begin
                            // Writes have no response phase
                            w_state_nxt      = c_IDLE;
                            w_last_owner_nxt = r_owner;
                        end else begin
                            w_state_nxt      = c_RSP;
                        end
                    end
                end
            end

            c_RSP: begin
                m_rready = w_owner_rready;
                if (w_own_d) begin
                    d_rdata  = m_rdata;
                    d_rvalid = m_rvalid;
                end else begin
                    i_rdata  = m_rdata;
                    i_rvalid = m_rvalid;
                end
                if (m_rvalid && w_owner_rready) begin
                    w_state_nxt      = c_IDLE;
                    w_last_owner_nxt = r_owner;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic        w_conflict;

    // One loser at most per cycle: the tie loser in IDLE, or a waiting
    // non-owner while the port is busy.
    always_comb begin
        w_conflict = 1'b0;
        case (r_state)
            c_IDLE:       w_conflict = i_req_valid & w_d_valid;
            c_REQ, c_RSP: w_conflict = w_own_d ? i_req_valid : w_d_valid;
            default:      w_conflict = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = '0;
`endif

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. A second
//               instance with FIX_PRIO=1 shares the stimulus and is checked
//               only during the repeated-tie sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid, i_rready, d_read, d_write, d_rready;
    logic        m_req_ready, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_wstrb;

    logic        i_req_ready, i_rvalid, d_req_ready, d_rvalid;
    logic        m_read, m_write, m_rready;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, conflict_cnt;
    logic [3:0]  m_wstrb;

    logic        i_req_ready_f, i_rvalid_f, d_req_ready_f, d_rvalid_f;
    logic        m_read_f, m_write_f, m_rready_f;
    logic [31:0] i_rdata_f, d_rdata_f, m_addr_f, m_wdata_f, conflict_cnt_f;
    logic [3:0]  m_wstrb_f;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FIX_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_addr(i_addr), .i_req_ready(i_req_ready),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_req_ready(d_req_ready), .d_rdata(d_rdata),
        .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_read(m_read),
        .m_write(m_write), .m_req_ready(m_req_ready), .m_rdata(m_rdata),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.FIX_PRIO(1)) dut_fix (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_addr(i_addr), .i_req_ready(i_req_ready_f),
        .i_rdata(i_rdata_f), .i_rvalid(i_rvalid_f), .i_rready(i_rready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_req_ready(d_req_ready_f), .d_rdata(d_rdata_f),
        .d_rvalid(d_rvalid_f), .d_rready(d_rready),
        .m_addr(m_addr_f), .m_wdata(m_wdata_f), .m_wstrb(m_wstrb_f),
        .m_read(m_read_f), .m_write(m_write_f), .m_req_ready(m_req_ready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready_f),
        .conflict_cnt(conflict_cnt_f)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        i_req_valid = 1'b0; i_addr  = '0; i_rready = 1'b0;
        d_read      = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        d_wstrb     = '0;   d_rready = 1'b0;
        m_req_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        tick();
        tick();
        // ---- reset state (rst still high) ----
        chk32("rst_state", 32'(dut.r_state), 32'(c_IDLE));
        chk1("rst_m_read", m_read, 1'b0);
        chk1("rst_m_write", m_write, 1'b0);
        chk1("rst_i_req_ready", i_req_ready, 1'b0);
        chk1("rst_d_req_ready", d_req_ready, 1'b0);
        chk1("rst_m_rready", m_rready, 1'b0);
        chk1("rst_i_rvalid", i_rvalid, 1'b0);
        chk32("rst_conflict_cnt", conflict_cnt, 32'd0);
        rst = 1'b0;

        // ---- single fetch ----
        i_req_valid = 1'b1; i_addr = 32'h100; i_rready = 1'b1; #1;
        chk1("fetch_idle_m_read", m_read, 1'b0);
        tick();                                         // REQ
        m_req_ready = 1'b1; #1;
        chk1("fetch_m_read", m_read, 1'b1);
        chk32("fetch_m_addr", m_addr, 32'h100);
        chk1("fetch_i_req_ready", i_req_ready, 1'b1);
        chk1("fetch_d_req_ready", d_req_ready, 1'b0);
        tick();                                         // RSP
        i_req_valid = 1'b0; m_req_ready = 1'b0; #1;
        chk1("fetch_m_rready", m_rready, 1'b1);
        chk1("fetch_i_rvalid_early", i_rvalid, 1'b0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h13; #1;
        chk1("fetch_i_rvalid", i_rvalid, 1'b1);
        chk32("fetch_i_rdata", i_rdata, 32'h13);
        chk1("fetch_d_rvalid", d_rvalid, 1'b0);
        chk32("fetch_d_rdata", d_rdata, 32'h0);
        tick();
        m_rvalid = 1'b0; #1;
        chk32("fetch_done_state", 32'(dut.r_state), 32'(c_IDLE));
        chk1("fetch_done_m_rready", m_rready, 1'b0);

        // ---- simultaneous read after reset: inst then data ----
        do_reset();
        i_req_valid = 1'b1; i_addr = 32'h200; i_rready = 1'b1;
        d_read = 1'b1; d_addr = 32'h300; d_rready = 1'b1;
        tick();                                         // REQ, inst
        m_req_ready = 1'b1; #1;
        chk32("sim_first_addr", m_addr, 32'h200);
        chk1("sim_first_i_ready", i_req_ready, 1'b1);
        chk1("sim_first_d_ready", d_req_ready, 1'b0);
        tick();                                         // RSP
        i_req_valid = 1'b0; m_req_ready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hAAAA0001; #1;
        chk1("sim_first_i_rvalid", i_rvalid, 1'b1);
        chk32("sim_first_i_rdata", i_rdata, 32'hAAAA0001);
        chk1("sim_first_d_rvalid", d_rvalid, 1'b0);
        tick();                                         // IDLE gap
        m_rvalid = 1'b0; #1;
        chk32("sim_gap_state", 32'(dut.r_state), 32'(c_IDLE));
        tick();                                         // REQ, data
        m_req_ready = 1'b1; #1;
        chk32("sim_second_addr", m_addr, 32'h300);
        chk1("sim_second_m_read", m_read, 1'b1);
        chk1("sim_second_d_ready", d_req_ready, 1'b1);
        chk1("sim_second_i_ready", i_req_ready, 1'b0);
        tick();                                         // RSP
        d_read = 1'b0; m_req_ready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hBBBB0002; #1;
        chk1("sim_second_d_rvalid", d_rvalid, 1'b1);
        chk32("sim_second_d_rdata", d_rdata, 32'hBBBB0002);
        chk1("sim_second_i_rvalid", i_rvalid, 1'b0);
        tick();
        m_rvalid = 1'b0; #1;
`ifdef MEM_ARB_PERF_EN
        chk32("sim_conflict_cnt", conflict_cnt, 32'd3);
`else
        chk32("sim_conflict_cnt", conflict_cnt, 32'd0);
`endif

        // ---- repeated ties: RR alternates I,D,I,D; FIX_PRIO=1 always D ----
        do_reset();
        i_req_valid = 1'b1; i_addr = 32'h400; i_rready = 1'b1;
        d_read = 1'b1; d_addr = 32'h500; d_rready = 1'b1;
        m_req_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            tick();                                     // REQ
            chk1("rr_i_grant", i_req_ready, ~k[0]);
            chk1("rr_d_grant", d_req_ready, k[0]);
            chk1("fix_d_grant", d_req_ready_f, 1'b1);
            chk1("fix_i_grant", i_req_ready_f, 1'b0);
            tick();                                     // RSP
            tick();                                     // IDLE
        end

        // ---- write (read+write both high) with delayed acceptance ----
        do_reset();
        d_write = 1'b1; d_read = 1'b1; d_addr = 32'h2000;
        d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        tick();                                         // REQ
        for (int k = 0; k < 3; k++) begin
            chk1("wr_m_write_held", m_write, 1'b1);
            chk1("wr_m_read", m_read, 1'b0);
            chk1("wr_d_ready_wait", d_req_ready, 1'b0);
            chk32("wr_state_req", 32'(dut.r_state), 32'(c_REQ));
            tick();
        end
        m_req_ready = 1'b1; #1;
        chk32("wr_m_addr", m_addr, 32'h2000);
        chk32("wr_m_wdata", m_wdata, 32'hDEADBEEF);
        chk32("wr_m_wstrb", 32'(m_wstrb), 32'h3);
        chk1("wr_d_ready", d_req_ready, 1'b1);
        tick();
        d_write = 1'b0; d_read = 1'b0; m_req_ready = 1'b0; #1;
        chk32("wr_state_idle", 32'(dut.r_state), 32'(c_IDLE));
        chk1("wr_m_write_off", m_write, 1'b0);

        // ---- data response back-pressure ----
        do_reset();
        d_read = 1'b1; d_addr = 32'h40; m_req_ready = 1'b1;
        tick();                                         // REQ
        tick();                                         // RSP
        d_read = 1'b0; m_req_ready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h55; d_rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1("bp_m_rready", m_rready, 1'b0);
            chk32("bp_state", 32'(dut.r_state), 32'(c_RSP));
            tick();
        end
        d_rready = 1'b1; #1;
        chk1("bp_m_rready_go", m_rready, 1'b1);
        chk1("bp_d_rvalid", d_rvalid, 1'b1);
        chk32("bp_d_rdata", d_rdata, 32'h55);
        tick();
        m_rvalid = 1'b0; #1;
        chk32("bp_state_idle", 32'(dut.r_state), 32'(c_IDLE));

        // ---- reset in RSP, late response ignored ----
        do_reset();
        i_req_valid = 1'b1; i_addr = 32'h600; i_rready = 1'b1; m_req_ready = 1'b1;
        tick();                                         // REQ
        tick();                                         // RSP
        i_req_valid = 1'b0; m_req_ready = 1'b0; #1;
        chk32("rr_rsp_state", 32'(dut.r_state), 32'(c_RSP));
        rst = 1'b1;
        tick();
        rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77; #1;
        chk1("late_i_rvalid", i_rvalid, 1'b0);
        chk1("late_d_rvalid", d_rvalid, 1'b0);
        chk1("late_m_rready", m_rready, 1'b0);
        chk32("late_state", 32'(dut.r_state), 32'(c_IDLE));
        tick();
        chk32("late_state_hold", 32'(dut.r_state), 32'(c_IDLE));
        m_rvalid = 1'b0;

        // ---- request withdrawn in REQ before acceptance ----
        d_read = 1'b1; d_addr = 32'h80; d_rready = 1'b1;
        tick();                                         // REQ
        chk1("drop_m_read_on", m_read, 1'b1);
        d_read = 1'b0; #1;
        chk1("drop_m_read_off", m_read, 1'b0);
        tick();
        chk32("drop_state", 32'(dut.r_state), 32'(c_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
